// File: rtl/mmm_pkg.sv
// Shared types and defaults for the multi-channel MMM issue/completion tracker.
package mmm_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STALL = 2'd1,
        S_ABORT = 2'd2
    } mmm_state_t;

    localparam int DEFAULT_TIMEOUT_CYC = 4096;

    typedef int unsigned ch_idx_t;

    // ch_sel comes from raw register bits, so it can name a channel that does not exist.
    function automatic logic ch_in_range(input ch_idx_t sel, input ch_idx_t num_ch);
        return (sel < num_ch);
    endfunction

endpackage

// File: rtl/mmm_watchdog.sv
// Saturating stall-cycle counter; expired marks the last tolerated stall cycle.
module mmm_watchdog
    import mmm_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en && (count != CNT_W'(TIMEOUT_CYC))) begin
            count <= count + CNT_W'(1);
        end
    end

    // count holds the stall cycles already completed, so this cycle is number count+1.
    assign expired = (count >= CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mmm_issue_ctrl.sv
// Per-channel busy tracking, start issue and wait stalling for NUM_CH MMM accelerators.
module mmm_issue_ctrl
    import mmm_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_mmm,
    input  logic              wait_mmm_finish,
    input  logic              wait_all,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic [NUM_CH-1:0] mmm_done,
    output logic [NUM_CH-1:0] mmm_start,
    output logic [NUM_CH-1:0] mmm_abort,
    output logic [NUM_CH-1:0] mmm_busy,
    output logic              mmm_stall,
    output logic              timeout_err,
    output logic              spurious_err,
    output logic [1:0]        fsm_state
);

    // Handshake: start_mmm / wait_mmm_finish are requests that the pipeline holds
    // stable while mmm_stall=1; a request is accepted in the first cycle mmm_stall=0.

    mmm_state_t        state, state_n;
    logic [NUM_CH-1:0] sel_vec;
    logic [NUM_CH-1:0] eb;
    logic [NUM_CH-1:0] start_vec;
    logic [NUM_CH-1:0] abort_vec;
    logic              start_req;
    logic              wait_req;
    logic              start_ok;
    logic              wait_ok;
    logic              satisfied;
    logic              issue;
    logic              stall;
    logic              set_timeout;
    logic              expired;
    logic              wd_clr;

    always_comb begin
        sel_vec = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(ch_sel) == i) sel_vec[i] = 1'b1;
        end
    end

    // A done pulse frees its channel in the same cycle it arrives.
    assign eb        = mmm_busy & ~mmm_done;
    assign start_req = start_mmm && ch_in_range(ch_idx_t'(ch_sel), ch_idx_t'(NUM_CH));
    assign wait_req  = wait_mmm_finish && !start_mmm;
    assign start_ok  = ((eb & sel_vec) == '0);
    assign wait_ok   = wait_all ? (eb == '0) : ((eb & sel_vec) == '0);
    assign satisfied = start_req ? start_ok : (wait_req ? wait_ok : 1'b1);
    assign issue     = start_req && start_ok;

    always_comb begin
        state_n     = state;
        start_vec   = '0;
        abort_vec   = '0;
        stall       = 1'b0;
        set_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                if (issue) start_vec = sel_vec;
                if (!satisfied) begin
                    stall   = 1'b1;
                    state_n = S_STALL;
                end
            end
            S_STALL: begin
                if (issue) start_vec = sel_vec;
                if (satisfied) begin
                    state_n = S_IDLE;
                end else begin
                    stall = 1'b1;
                    if (expired) state_n = S_ABORT;
                end
            end
            S_ABORT: begin
                set_timeout = 1'b1;
                if (start_req || (wait_req && !wait_all)) begin
                    abort_vec = sel_vec & eb;
                end else if (wait_req) begin
                    abort_vec = eb;
                end
                // The forced clear frees the channel, so a pending start goes out now.
                if (start_req) start_vec = sel_vec;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign wd_clr = (state_n == S_IDLE);

    mmm_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (wd_clr),
        .en     (stall),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            mmm_busy     <= '0;
            timeout_err  <= 1'b0;
            spurious_err <= 1'b0;
        end else begin
            state        <= state_n;
            mmm_busy     <= (mmm_busy & ~mmm_done & ~abort_vec) | start_vec;
            timeout_err  <= timeout_err | set_timeout;
            spurious_err <= spurious_err | (|(mmm_done & ~mmm_busy));
        end
    end

    assign mmm_start = start_vec & {NUM_CH{~reset}};
    assign mmm_abort = abort_vec & {NUM_CH{~reset}};
    assign mmm_stall = stall & ~reset;
    assign fsm_state = state;

endmodule

// File: tb/tb_mmm_issue_ctrl.sv
// Directed bench for mmm_issue_ctrl: a 2-channel instance plus a 3-channel one for range checks.
module tb_mmm_issue_ctrl;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_ABORT = 2'd2;

    logic       clk;
    logic       reset;
    int         checks;
    int         failures;

    logic       a_start, a_wait, a_wait_all;
    logic [0:0] a_ch;
    logic [1:0] a_done, a_start_o, a_abort, a_busy;
    logic       a_stall, a_terr, a_serr;
    logic [1:0] a_state;

    logic       b_start, b_wait, b_wait_all;
    logic [1:0] b_ch;
    logic [2:0] b_done, b_start_o, b_abort, b_busy;
    logic       b_stall, b_terr, b_serr;
    logic [1:0] b_state;

    mmm_issue_ctrl #(.NUM_CH(2), .TIMEOUT_CYC(8)) dut_a (
        .clk(clk), .reset(reset), .start_mmm(a_start), .wait_mmm_finish(a_wait),
        .wait_all(a_wait_all), .ch_sel(a_ch), .mmm_done(a_done), .mmm_start(a_start_o),
        .mmm_abort(a_abort), .mmm_busy(a_busy), .mmm_stall(a_stall),
        .timeout_err(a_terr), .spurious_err(a_serr), .fsm_state(a_state)
    );

    mmm_issue_ctrl #(.NUM_CH(3), .TIMEOUT_CYC(8)) dut_b (
        .clk(clk), .reset(reset), .start_mmm(b_start), .wait_mmm_finish(b_wait),
        .wait_all(b_wait_all), .ch_sel(b_ch), .mmm_done(b_done), .mmm_start(b_start_o),
        .mmm_abort(b_abort), .mmm_busy(b_busy), .mmm_stall(b_stall),
        .timeout_err(b_terr), .spurious_err(b_serr), .fsm_state(b_state)
    );

    // Clock / reset: inputs change on the falling edge, outputs are sampled 1ns later.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_a(input logic s, input logic w, input logic wa, input logic [0:0] ch,
                           input logic [1:0] d);
        @(negedge clk);
        a_start = s; a_wait = w; a_wait_all = wa; a_ch = ch; a_done = d;
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1; a_start = 1'b1; a_ch = 1'b0;
        #1;
        checks++; if (a_start_o !== 2'b00) begin failures++; $display("FAIL reset_no_pulse got=%b exp=00", a_start_o); end
        checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", a_stall); end
        drive_a(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        reset = 1'b0;
        #1;
        checks++; if (a_busy !== 2'b00) begin failures++; $display("FAIL reset_busy got=%b exp=00", a_busy); end
        checks++; if ({a_terr, a_serr} !== 2'b00) begin failures++; $display("FAIL reset_errs got=%b exp=00", {a_terr, a_serr}); end
        checks++; if (a_state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", a_state, ST_IDLE); end
        checks++; if (a_abort !== 2'b00) begin failures++; $display("FAIL reset_abort got=%b exp=00", a_abort); end
    endtask

    task automatic test_start_idle;
        drive_a(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        checks++; if (a_start_o !== 2'b01) begin failures++; $display("FAIL idle_start got=%b exp=01", a_start_o); end
        checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL idle_start_stall got=%b exp=0", a_stall); end
        drive_a(1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
        checks++; if (a_busy !== 2'b01) begin failures++; $display("FAIL idle_start_busy got=%b exp=01", a_busy); end
        drive_a(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        checks++; if (a_busy !== 2'b00) begin failures++; $display("FAIL idle_done_clear got=%b exp=00", a_busy); end
    endtask

    task automatic test_start_busy;
        drive_a(1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
        checks++; if (a_start_o !== 2'b10) begin failures++; $display("FAIL busy_first_start got=%b exp=10", a_start_o); end
        for (int k = 1; k <= 6; k++) begin
            drive_a(1'b1, 1'b0, 1'b0, 1'b1, (k == 6) ? 2'b10 : 2'b00);
            checks++; if (a_stall !== (k < 6)) begin failures++; $display("FAIL busy_stall_c%0d got=%b exp=%b", k, a_stall, (k < 6)); end
            checks++; if (a_start_o !== ((k == 6) ? 2'b10 : 2'b00)) begin failures++; $display("FAIL busy_start_c%0d got=%b", k, a_start_o); end
        end
        drive_a(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        checks++; if (a_busy !== 2'b10) begin failures++; $display("FAIL busy_reissue_busy got=%b exp=10", a_busy); end
        checks++; if (a_state !== ST_IDLE) begin failures++; $display("FAIL busy_state got=%0d exp=0", a_state); end
        drive_a(1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
        drive_a(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        checks++; if (a_busy !== 2'b00) begin failures++; $display("FAIL busy_cleanup got=%b exp=00", a_busy); end
    endtask

    task automatic test_back_to_back_wait_all;
        drive_a(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        checks++; if (a_start_o !== 2'b01) begin failures++; $display("FAIL b2b_start0 got=%b exp=01", a_start_o); end
        drive_a(1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
        checks++; if (a_start_o !== 2'b10) begin failures++; $display("FAIL b2b_start1 got=%b exp=10", a_start_o); end
        checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL b2b_stall got=%b exp=0", a_stall); end
        for (int k = 0; k <= 7; k++) begin
            drive_a(1'b0, 1'b1, 1'b1, 1'b0, (k == 3) ? 2'b01 : ((k == 7) ? 2'b10 : 2'b00));
            if (k == 0) begin
                checks++; if (a_busy !== 2'b11) begin failures++; $display("FAIL wall_busy got=%b exp=11", a_busy); end
            end
            checks++; if (a_stall !== (k < 7)) begin failures++; $display("FAIL wall_stall_c%0d got=%b exp=%b", k, a_stall, (k < 7)); end
        end
        drive_a(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        checks++; if (a_busy !== 2'b00) begin failures++; $display("FAIL wall_busy_end got=%b exp=00", a_busy); end
        checks++; if (a_state !== ST_IDLE) begin failures++; $display("FAIL wall_state got=%0d exp=0", a_state); end
        checks++; if (a_serr !== 1'b0) begin failures++; $display("FAIL wall_serr got=%b exp=0", a_serr); end
    endtask

    task automatic test_timeout;
        drive_a(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        for (int k = 0; k <= 7; k++) begin
            drive_a(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
            checks++; if (a_stall !== 1'b1) begin failures++; $display("FAIL to_stall_c%0d got=%b exp=1", k, a_stall); end
            if (k == 1) begin
                checks++; if (a_state !== ST_STALL) begin failures++; $display("FAIL to_state_stall got=%0d exp=1", a_state); end
            end
        end
        drive_a(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        checks++; if (a_state !== ST_ABORT) begin failures++; $display("FAIL to_state_abort got=%0d exp=2", a_state); end
        checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL to_abort_stall got=%b exp=0", a_stall); end
        checks++; if (a_abort !== 2'b01) begin failures++; $display("FAIL to_abort got=%b exp=01", a_abort); end
        drive_a(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        checks++; if (a_busy !== 2'b00) begin failures++; $display("FAIL to_busy got=%b exp=00", a_busy); end
        checks++; if (a_terr !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", a_terr); end
        checks++; if (a_abort !== 2'b00) begin failures++; $display("FAIL to_abort_once got=%b exp=00", a_abort); end
        checks++; if (a_state !== ST_IDLE) begin failures++; $display("FAIL to_state_idle got=%0d exp=0", a_state); end
    endtask

    task automatic test_spurious_and_same_cycle;
        drive_a(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        drive_a(1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
        drive_a(1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
        checks++; if (a_serr !== 1'b1) begin failures++; $display("FAIL spur_err got=%b exp=1", a_serr); end
        checks++; if (a_busy !== 2'b01) begin failures++; $display("FAIL spur_busy got=%b exp=01", a_busy); end
        checks++; if (a_start_o !== 2'b01) begin failures++; $display("FAIL same_start got=%b exp=01", a_start_o); end
        checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL same_stall got=%b exp=0", a_stall); end
        drive_a(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        checks++; if (a_busy !== 2'b01) begin failures++; $display("FAIL same_busy got=%b exp=01", a_busy); end
        drive_a(1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
        drive_a(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        checks++; if (a_busy !== 2'b00) begin failures++; $display("FAIL same_cleanup got=%b exp=00", a_busy); end
    endtask

    task automatic test_reset_mid_stall;
        drive_a(1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
        for (int k = 0; k < 3; k++) drive_a(1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
        checks++; if (a_stall !== 1'b1) begin failures++; $display("FAIL rms_pre_stall got=%b exp=1", a_stall); end
        reset = 1'b1;
        #1;
        checks++; if ({a_stall, a_start_o, a_abort} !== 5'b0) begin failures++; $display("FAIL rms_reset_cycle got=%b exp=00000", {a_stall, a_start_o, a_abort}); end
        drive_a(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        reset = 1'b0;
        #1;
        checks++; if (a_state !== ST_IDLE) begin failures++; $display("FAIL rms_state got=%0d exp=0", a_state); end
        checks++; if ({a_busy, a_stall, a_abort, a_terr, a_serr} !== 7'b0) begin failures++; $display("FAIL rms_outputs got=%b exp=0000000", {a_busy, a_stall, a_abort, a_terr, a_serr}); end
    endtask

    task automatic test_ch_range;
        @(negedge clk);
        b_start = 1'b1; b_ch = 2'd3;
        #1;
        checks++; if (b_start_o !== 3'b000) begin failures++; $display("FAIL range_start got=%b exp=000", b_start_o); end
        checks++; if (b_stall !== 1'b0) begin failures++; $display("FAIL range_stall got=%b exp=0", b_stall); end
        @(negedge clk);
        b_ch = 2'd2;
        #1;
        checks++; if (b_busy !== 3'b000) begin failures++; $display("FAIL range_busy got=%b exp=000", b_busy); end
        checks++; if (b_start_o !== 3'b100) begin failures++; $display("FAIL range_ch2_start got=%b exp=100", b_start_o); end
        @(negedge clk);
        b_start = 1'b0;
        #1;
        checks++; if (b_busy !== 3'b100) begin failures++; $display("FAIL range_ch2_busy got=%b exp=100", b_busy); end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1;
        a_start = 1'b0; a_wait = 1'b0; a_wait_all = 1'b0; a_ch = 1'b0; a_done = 2'b00;
        b_start = 1'b0; b_wait = 1'b0; b_wait_all = 1'b0; b_ch = 2'd0; b_done = 3'b000;
        repeat (2) @(posedge clk);
        test_reset;
        test_start_idle;
        test_start_busy;
        test_back_to_back_wait_all;
        test_timeout;
        test_spurious_and_same_cycle;
        test_reset_mid_stall;
        test_ch_range;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
